// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU operand/result bus, retire status and debug
// read port of the ALU sequencer, bundled for connection to the sequencer.
interface alu_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opc;
    logic [15:0] alu_res;
    logic        done;
    logic [15:0] done_data;
    logic [2:0]  done_rd;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    // Environment side: issues instructions, closes the ALU loop, observes retires.
    modport master (
        output instr_valid, instr, alu_res, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_opc, done, done_data, done_rd,
               illegal, dbg_data
    );

    // Sequencer side.
    modport slave (
        input  instr_valid, instr, alu_res, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_opc, done, done_data, done_rd,
               illegal, dbg_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer (IDLE/DECODE/EXEC/WB) driving an external
// combinational 16-bit ALU, with an 8x16 register file (r0 hardwired to 0).
module alu_sequencer (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    localparam logic [3:0] OP_LI = 4'b1111;

    state_t      state, state_nxt;
    logic [15:0] instr_q;
    logic [15:0] res_q;
    logic [15:0] opa_q;
    logic [15:0] opb_q;
    logic [3:0]  opc_q;
    logic [15:0] regs [8];

    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;

    assign op = instr_q[15:12];
    assign rd = instr_q[11:9];
    assign rs = instr_q[8:6];
    assign rt = instr_q[5:3];

    function automatic logic is_legal(input logic [3:0] o);
        return (o <= 4'b0101) || (o == OP_LI);
    endfunction

    // r0 is never written, but the read is forced to zero so that holds regardless.
    function automatic logic [15:0] rd_reg(input logic [2:0] a, input logic [15:0] r [8]);
        return (a == 3'd0) ? 16'h0000 : r[a];
    endfunction

    // State register; reset drops any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: fixed walk through the four states, waiting only in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.instr_valid) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.instr_ready = (state == IDLE);
        bus.done        = (state == WB);
        bus.illegal     = (state == WB) && !is_legal(op);
    end

    // Instruction latch, operand fetch and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.instr_valid) instr_q <= bus.instr;
                DECODE: begin
                    opa_q <= rd_reg(rs, regs);
                    opb_q <= rd_reg(rt, regs);
                    opc_q <= (op == OP_LI) ? 4'b0000 : op;
                end
                EXEC: res_q <= (op == OP_LI) ? {7'b0, instr_q[8:0]} : bus.alu_res;
                default: ;
            endcase
        end
    end

    // Register file write-back; illegal ops and r0 targets leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (state == WB && is_legal(op) && rd != 3'd0) begin
            regs[rd] <= res_q;
        end
    end

    assign bus.alu_a     = opa_q;
    assign bus.alu_b     = opb_q;
    assign bus.alu_opc   = opc_q;
    assign bus.done_data = res_q;
    assign bus.done_rd   = rd;
    assign bus.dbg_data  = rd_reg(bus.dbg_addr, regs);
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected retires,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc_exec;
        int          cyc_done;
        logic        chk_ops;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  opc;
        logic [15:0] data;
        logic [2:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m [8];
    int          last_acc = -100;

    // Behavioural ALU: the combinational unit the sequencer drives.
    function automatic logic [15:0] alu_ref(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return (a < b) ? 16'd1 : 16'd0;
            4'd3: return a | b;
            4'd4: return a & b;
            4'd5: return (b >= 16) ? 16'd0 : (a << b[3:0]);
            default: return 16'hFFFF;
        endcase
    endfunction

    always_comb bus.alu_res = alu_ref(bus.alu_opc, bus.alu_a, bus.alu_b);

    function automatic logic [15:0] mk(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
        return {o, d, s, t, 3'b000};
    endfunction

    function automatic logic [15:0] mk_li(input logic [2:0] d, input logic [8:0] imm);
        return {4'b1111, d, imm};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: operand check during EXEC, retire check whenever done is seen.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && cyc == q[0].cyc_exec) begin
                if (q[0].chk_ops) begin
                    chk("exec_alu_a", bus.alu_a, q[0].a);
                    chk("exec_alu_b", bus.alu_b, q[0].b);
                end
                chk("exec_alu_opc", {12'b0, bus.alu_opc}, {12'b0, q[0].opc});
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {15'b0, bus.done}, 16'd0);
                end else begin
                    chk("done_latency", 16'(cyc), 16'(q[0].cyc_done));
                    chk("done_data", bus.done_data, q[0].data);
                    chk("done_rd", {13'b0, bus.done_rd}, {13'b0, q[0].rd});
                    chk("illegal", {15'b0, bus.illegal}, {15'b0, q[0].ill});
                    void'(q.pop_front());
                end
            end else begin
                if (bus.illegal) chk("illegal_without_done", {15'b0, bus.illegal}, 16'd0);
                if (q.size() > 0 && cyc > q[0].cyc_done) begin
                    chk("done_timeout", 16'd0, 16'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Issue one instruction; valid is left high so consecutive issues hold it continuously.
    task automatic issue(input logic [15:0] w);
        exp_t        e;
        int          n;
        logic        held;
        logic [3:0]  o;
        logic [2:0]  d, s, t;
        held = bus.instr_valid;
        n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            chk("ready_timeout", 16'd0, 16'd1);
            return;
        end
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        @(posedge clk);
        #1;
        if (held && last_acc >= 0) chk("accept_spacing", 16'(cyc - last_acc), 16'd4);
        last_acc = cyc;
        o = w[15:12]; d = w[11:9]; s = w[8:6]; t = w[5:3];
        e.cyc_exec = cyc + 1;
        e.cyc_done = cyc + 2;
        e.chk_ops  = (o != 4'b1111);
        e.a        = m[s];
        e.b        = m[t];
        e.opc      = (o == 4'b1111) ? 4'b0000 : o;
        e.data     = (o == 4'b1111) ? {7'b0, w[8:0]} : alu_ref(o, m[s], m[t]);
        e.rd       = d;
        e.ill      = !((o <= 4'd5) || (o == 4'b1111));
        if (!e.ill && d != 3'd0) m[d] = e.data;
        q.push_back(e);
    endtask

    task automatic go_idle();
        bus.instr_valid = 1'b0;
        last_acc = -100;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) chk("drain_timeout", 16'(q.size()), 16'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            chk({tag, "_dbg_r", $sformatf("%0d", i)}, bus.dbg_data, m[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) m[i] = 16'h0;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
        bus.dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {15'b0, bus.instr_ready}, 16'd1);
        chk("rst_done", {15'b0, bus.done}, 16'd0);
        chk("rst_alu_a", bus.alu_a, 16'h0);
        chk("rst_alu_opc", {12'b0, bus.alu_opc}, 16'h0);
        chk("rst_done_data", bus.done_data, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs("reset");
        chk("idle_ready", {15'b0, bus.instr_ready}, 16'd1);

        // Directed sequence with valid held high between instructions.
        issue(mk_li(3'd1, 9'd5));
        issue(mk_li(3'd2, 9'd3));
        issue(mk(4'd0, 3'd3, 3'd1, 3'd2));
        issue(mk_li(3'd1, 9'd3));
        issue(mk_li(3'd2, 9'd5));
        issue(mk(4'd1, 3'd4, 3'd1, 3'd2));
        issue(mk(4'd2, 3'd5, 3'd1, 3'd2));
        issue(mk(4'd2, 3'd5, 3'd2, 3'd1));
        issue(mk(4'd5, 3'd6, 3'd1, 3'd2));
        issue(mk_li(3'd7, 9'd16));
        issue(mk(4'd5, 3'd6, 3'd1, 3'd7));
        issue(mk(4'd7, 3'd1, 3'd2, 3'd3));
        issue(mk_li(3'd0, 9'h1FF));
        go_idle();
        drain();
        check_regs("directed");
        chk("r4_sub", m[4], 16'hFFFE);

        // Reset during EXEC of an add: no retire, registers cleared.
        issue(mk(4'd0, 3'd3, 3'd1, 3'd2));
        go_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) m[i] = 16'h0;
        #1;
        chk("midrst_ready", {15'b0, bus.instr_ready}, 16'd1);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_done", {15'b0, bus.done}, 16'd0);
            chk("midrst_ready_held", {15'b0, bus.instr_ready}, 16'd1);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_done", {15'b0, bus.done}, 16'd0);
        end
        check_regs("midrst");

        // Randomized instruction stream with occasional idle gaps.
        for (int k = 0; k < 60; k++) begin
            logic [3:0]  o;
            logic [15:0] w;
            case ($urandom_range(0, 9))
                0, 1:    o = 4'b1111;
                2:       o = 4'($urandom_range(6, 14));
                default: o = 4'($urandom_range(0, 5));
            endcase
            w = 16'($urandom);
            w[15:12] = o;
            if (o == 4'd5 && $urandom_range(0, 1) == 1) w[5:3] = w[8:6];
            issue(w);
            if ($urandom_range(0, 3) == 0) begin
                go_idle();
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
        end
        go_idle();
        drain();
        check_regs("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
